// File: rtl/fv_ccp_tag_scan_checker_if.sv
// rtl/fv_ccp_tag_scan_checker_if.sv - CCP tag RAM read port bundle for the tag scan checker
interface fv_ccp_tag_scan_checker_if #(
    parameter int BNK_W  = 1,
    parameter int IDX_W  = 9,
    parameter int DATA_W = 104
) ();
    logic              tag_rd_req;
    logic [BNK_W-1:0]  tag_rd_bank;
    logic [IDX_W-1:0]  tag_rd_index;
    logic              tag_rd_gnt;
    logic              tag_rd_valid;
    logic [DATA_W-1:0] tag_rd_data;

    // Scanner side: issues requests, receives grant and read data
    modport master (
        output tag_rd_req,
        output tag_rd_bank,
        output tag_rd_index,
        input  tag_rd_gnt,
        input  tag_rd_valid,
        input  tag_rd_data
    );

    // Tag RAM side: accepts requests, returns grant and read data
    modport slave (
        input  tag_rd_req,
        input  tag_rd_bank,
        input  tag_rd_index,
        output tag_rd_gnt,
        output tag_rd_valid,
        output tag_rd_data
    );
endinterface

// File: rtl/fv_ccp_tag_scan_checker.sv
// rtl/fv_ccp_tag_scan_checker.sv - scans every CCP tag set and checks way uniqueness / invalid-zero invariants
module fv_ccp_tag_scan_checker #(
    parameter int         N_WAYS      = 4,
    parameter int         N_TAG_BANKS = 2,
    parameter int         N_SETS      = 1024,
    parameter int         TAG_W       = 24,
    parameter int         STATE_W     = 2,
    parameter logic [1:0] CHECK_MASK  = 2'b11,
    parameter int         TIMEOUT     = 64,
    parameter int         CNT_W       = 16,
    localparam int SET_PER_BANK = N_SETS / N_TAG_BANKS,
    localparam int BNK_W        = (N_TAG_BANKS > 1) ? $clog2(N_TAG_BANKS) : 1,
    localparam int IDX_W        = (SET_PER_BANK > 1) ? $clog2(SET_PER_BANK) : 1,
    localparam int SLOT_W       = TAG_W + STATE_W,
    localparam int DATA_W       = N_WAYS * SLOT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic                          i_abort,
    fv_ccp_tag_scan_checker_if.master     rd,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err_dup,
    output logic                          o_err_inv_tag,
    output logic                          o_err_timeout,
    output logic [BNK_W-1:0]              o_first_err_bank,
    output logic [IDX_W-1:0]              o_first_err_index,
    output logic [N_WAYS-1:0]             o_first_err_ways,
    output logic [CNT_W-1:0]              o_err_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BNK_W-1:0] BNK_LAST = BNK_W'(N_TAG_BANKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SET_PER_BANK - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic               r_busy;
    logic               r_done;
    logic [BNK_W-1:0]   r_bank;
    logic [IDX_W-1:0]   r_index;
    logic [TMR_W-1:0]   r_tmr;
    logic [DATA_W-1:0]  r_data;
    logic               r_err_dup;
    logic               r_err_inv_tag;
    logic               r_err_timeout;
    logic               r_first_seen;
    logic [BNK_W-1:0]   r_first_bank;
    logic [IDX_W-1:0]   r_first_index;
    logic [N_WAYS-1:0]  r_first_ways;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [TAG_W-1:0]   w_tag   [N_WAYS];
    logic [STATE_W-1:0] w_state [N_WAYS];
    logic [N_WAYS-1:0]  w_dup_ways;
    logic [N_WAYS-1:0]  w_inv_ways;
    logic [N_WAYS-1:0]  w_fail_ways;
    logic               w_fail;
    logic               w_dup_hit;
    logic               w_inv_hit;
    logic               w_last_set;

    // Each way slot is {tag, state}; state sits in the low bits
    for (genvar g = 0; g < N_WAYS; g++) begin : g_split
        assign w_state[g] = r_data[g*SLOT_W +: STATE_W];
        assign w_tag[g]   = r_data[g*SLOT_W + STATE_W +: TAG_W];
    end

    // Per-set invariant evaluation on the latched read data
    always_comb begin
        w_dup_ways = '0;
        w_inv_ways = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if ((w_state[i] == '0) && (w_tag[i] != '0)) begin
                w_inv_ways[i] = 1'b1;
            end
            for (int j = i + 1; j < N_WAYS; j++) begin
                if ((w_state[i] != '0) && (w_state[j] != '0) && (w_tag[i] == w_tag[j])) begin
                    w_dup_ways[i] = 1'b1;
                    w_dup_ways[j] = 1'b1;
                end
            end
        end
    end

    assign w_dup_hit   = CHECK_MASK[0] & (|w_dup_ways);
    assign w_inv_hit   = CHECK_MASK[1] & (|w_inv_ways);
    assign w_fail_ways = ({N_WAYS{CHECK_MASK[0]}} & w_dup_ways) |
                         ({N_WAYS{CHECK_MASK[1]}} & w_inv_ways);
    assign w_fail      = |w_fail_ways;
    assign w_last_set  = (r_bank == BNK_LAST) && (r_index == IDX_LAST);

    // Scan sequencer: request, wait for data, check, advance; abort overrides everything outside IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bank        <= '0;
            r_index       <= '0;
            r_tmr         <= '0;
            r_data        <= '0;
            r_err_dup     <= 1'b0;
            r_err_inv_tag <= 1'b0;
            r_err_timeout <= 1'b0;
            r_first_seen  <= 1'b0;
            r_first_bank  <= '0;
            r_first_index <= '0;
            r_first_ways  <= '0;
            r_err_cnt     <= '0;
        end else if ((r_state != S_IDLE) && i_abort) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state       <= S_REQ;
                        r_req         <= 1'b1;
                        r_busy        <= 1'b1;
                        r_bank        <= '0;
                        r_index       <= '0;
                        r_err_dup     <= 1'b0;
                        r_err_inv_tag <= 1'b0;
                        r_err_timeout <= 1'b0;
                        r_first_seen  <= 1'b0;
                        r_first_bank  <= '0;
                        r_first_index <= '0;
                        r_first_ways  <= '0;
                        r_err_cnt     <= '0;
                    end
                end
                S_REQ: begin
                    if (rd.tag_rd_gnt) begin
                        r_req   <= 1'b0;
                        r_tmr   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rd.tag_rd_valid) begin
                        r_data  <= rd.tag_rd_data;
                        r_state <= S_CHECK;
                    end else if (r_tmr == TMR_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_fail) begin
                        if (r_err_cnt != {CNT_W{1'b1}}) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (w_dup_hit) begin
                            r_err_dup <= 1'b1;
                        end
                        if (w_inv_hit) begin
                            r_err_inv_tag <= 1'b1;
                        end
                        if (!r_first_seen) begin
                            r_first_seen  <= 1'b1;
                            r_first_bank  <= r_bank;
                            r_first_index <= r_index;
                            r_first_ways  <= w_fail_ways;
                        end
                    end
                    if (w_last_set) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (r_index == IDX_LAST) begin
                            r_index <= '0;
                            r_bank  <= r_bank + 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign rd.tag_rd_req   = r_req;
    assign rd.tag_rd_bank  = r_bank;
    assign rd.tag_rd_index = r_index;

    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_err_dup         = r_err_dup;
    assign o_err_inv_tag     = r_err_inv_tag;
    assign o_err_timeout     = r_err_timeout;
    assign o_first_err_bank  = r_first_bank;
    assign o_first_err_index = r_first_index;
    assign o_first_err_ways  = r_first_ways;
    assign o_err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_fv_ccp_tag_scan_checker.sv
// tb/tb_fv_ccp_tag_scan_checker.sv - scoreboard bench for fv_ccp_tag_scan_checker
module tb_fv_ccp_tag_scan_checker;

    typedef struct {
        logic       dup;
        logic       inv;
        logic       tmo;
        logic       bank;
        logic [1:0] idx;
        logic [3:0] ways;
        int         cnt;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;

    int n_tests = 0;
    int n_fail  = 0;

    logic       busy  [3];
    logic       done  [3];
    logic       dup   [3];
    logic       inv   [3];
    logic       tmo   [3];
    logic       fbank [3];
    logic [1:0] fidx  [3];
    logic [3:0] fways [3];
    logic [3:0] cnt_ab[2];
    logic [1:0] cnt_c;

    logic [39:0] mem [2][4];
    logic        wh_en;
    logic        wh_bank;
    logic [1:0]  wh_idx;

    res_t       q0[$];
    res_t       q1[$];
    res_t       q2[$];
    logic [2:0] addr_q[$];

    fv_ccp_tag_scan_checker_if #(.BNK_W(1), .IDX_W(2), .DATA_W(40)) if_a ();
    fv_ccp_tag_scan_checker_if #(.BNK_W(1), .IDX_W(2), .DATA_W(40)) if_b ();
    fv_ccp_tag_scan_checker_if #(.BNK_W(1), .IDX_W(2), .DATA_W(40)) if_c ();

    fv_ccp_tag_scan_checker #(.N_WAYS(4), .N_TAG_BANKS(2), .N_SETS(8), .TAG_W(8), .STATE_W(2),
                              .CHECK_MASK(2'b11), .TIMEOUT(4), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort), .rd(if_a),
        .o_busy(busy[0]), .o_done(done[0]), .o_err_dup(dup[0]), .o_err_inv_tag(inv[0]),
        .o_err_timeout(tmo[0]), .o_first_err_bank(fbank[0]), .o_first_err_index(fidx[0]),
        .o_first_err_ways(fways[0]), .o_err_cnt(cnt_ab[0]));

    fv_ccp_tag_scan_checker #(.N_WAYS(4), .N_TAG_BANKS(2), .N_SETS(8), .TAG_W(8), .STATE_W(2),
                              .CHECK_MASK(2'b01), .TIMEOUT(4), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort), .rd(if_b),
        .o_busy(busy[1]), .o_done(done[1]), .o_err_dup(dup[1]), .o_err_inv_tag(inv[1]),
        .o_err_timeout(tmo[1]), .o_first_err_bank(fbank[1]), .o_first_err_index(fidx[1]),
        .o_first_err_ways(fways[1]), .o_err_cnt(cnt_ab[1]));

    fv_ccp_tag_scan_checker #(.N_WAYS(4), .N_TAG_BANKS(2), .N_SETS(8), .TAG_W(8), .STATE_W(2),
                              .CHECK_MASK(2'b11), .TIMEOUT(4), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .i_start(start), .i_abort(abort), .rd(if_c),
        .o_busy(busy[2]), .o_done(done[2]), .o_err_dup(dup[2]), .o_err_inv_tag(inv[2]),
        .o_err_timeout(tmo[2]), .o_first_err_bank(fbank[2]), .o_first_err_index(fidx[2]),
        .o_first_err_ways(fways[2]), .o_err_cnt(cnt_c));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        if (k == 2) return {30'd0, cnt_c};
        return {28'd0, cnt_ab[k]};
    endfunction

    function automatic res_t mk_res(input logic d, input logic iv, input logic t, input logic b,
                                    input logic [1:0] ix, input logic [3:0] w, input int c);
        res_t r;
        r.dup = d; r.inv = iv; r.tmo = t; r.bank = b; r.idx = ix; r.ways = w; r.cnt = c;
        return r;
    endfunction

    function automatic logic [39:0] pack(input logic [7:0] t0, input logic [7:0] t1,
                                         input logic [7:0] t2, input logic [7:0] t3,
                                         input logic [1:0] s0, input logic [1:0] s1,
                                         input logic [1:0] s2, input logic [1:0] s3);
        return {t3, s3, t2, s2, t1, s1, t0, s0};
    endfunction

    task automatic fill_clean();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 4; i++)
                mem[b][i] = pack(8'd1, 8'd2, 8'd3, 8'd4, 2'd1, 2'd1, 2'd1, 2'd1);
    endtask

    task automatic push_exp(input res_t ra, input res_t rb, input res_t rc);
        q0.push_back(ra);
        q1.push_back(rb);
        q2.push_back(rc);
    endtask

    task automatic push_addrs(input int n);
        for (int k = 0; k < n; k++) addr_q.push_back(3'(k));
    endtask

    task automatic check_outputs(input int k, input res_t e);
        chk($sformatf("dut%0d_err_dup", k), {31'd0, dup[k]}, {31'd0, e.dup});
        chk($sformatf("dut%0d_err_inv_tag", k), {31'd0, inv[k]}, {31'd0, e.inv});
        chk($sformatf("dut%0d_err_timeout", k), {31'd0, tmo[k]}, {31'd0, e.tmo});
        chk($sformatf("dut%0d_first_bank", k), {31'd0, fbank[k]}, {31'd0, e.bank});
        chk($sformatf("dut%0d_first_index", k), {30'd0, fidx[k]}, {30'd0, e.idx});
        chk($sformatf("dut%0d_first_ways", k), {28'd0, fways[k]}, {28'd0, e.ways});
        chk($sformatf("dut%0d_err_cnt", k), cnt_of(k), e.cnt);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb();
        int n = 0;
        while (((q0.size() + q1.size() + q2.size()) != 0) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("scan_results_pending", q0.size() + q1.size() + q2.size(), 0);
        chk("reads_pending", addr_q.size(), 0);
    endtask

    // Tag RAM responder: grants a held request at once, returns data one cycle later
    initial begin
        logic       pend;
        logic       pb;
        logic [1:0] pi;
        pend = 1'b0; pb = 1'b0; pi = 2'd0;
        if_a.tag_rd_gnt = 1'b0; if_a.tag_rd_valid = 1'b0; if_a.tag_rd_data = '0;
        if_b.tag_rd_gnt = 1'b0; if_b.tag_rd_valid = 1'b0; if_b.tag_rd_data = '0;
        if_c.tag_rd_gnt = 1'b0; if_c.tag_rd_valid = 1'b0; if_c.tag_rd_data = '0;
        forever begin
            logic        v;
            logic        g;
            logic [39:0] d;
            @(negedge clk);
            v = pend && !(wh_en && (pb == wh_bank) && (pi == wh_idx));
            d = v ? mem[pb][pi] : 40'd0;
            pend = 1'b0;
            g = 1'b0;
            if (if_a.tag_rd_req && !reset) begin
                g = 1'b1; pend = 1'b1; pb = if_a.tag_rd_bank; pi = if_a.tag_rd_index;
            end
            if_a.tag_rd_gnt = g; if_a.tag_rd_valid = v; if_a.tag_rd_data = d;
            if_b.tag_rd_gnt = g; if_b.tag_rd_valid = v; if_b.tag_rd_data = d;
            if_c.tag_rd_gnt = g; if_c.tag_rd_valid = v; if_c.tag_rd_data = d;
        end
    end

    // Monitor: checks read addresses on grant and scan results on done
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (if_a.tag_rd_req && if_a.tag_rd_gnt) begin
                    if (addr_q.size() == 0) begin
                        chk("unexpected_read", {29'd0, if_a.tag_rd_bank, if_a.tag_rd_index}, 32'hFFFF_FFFF);
                    end else begin
                        logic [2:0] ea;
                        ea = addr_q.pop_front();
                        chk("read_addr", {29'd0, if_a.tag_rd_bank, if_a.tag_rd_index}, {29'd0, ea});
                    end
                end
                for (int k = 0; k < 3; k++) begin
                    if (done[k]) begin
                        int qs;
                        qs = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
                        if (qs == 0) begin
                            chk($sformatf("dut%0d_unexpected_done", k), 32'd1, 32'd0);
                        end else begin
                            res_t e;
                            e = (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
                            check_outputs(k, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t z;
        int   cnt;
        z = mk_res(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 0);
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        wh_en = 1'b0; wh_bank = 1'b0; wh_idx = 2'd0;
        fill_clean();

        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_outputs(k, z);
            chk($sformatf("dut%0d_reset_busy", k), {31'd0, busy[k]}, 32'd0);
            chk($sformatf("dut%0d_reset_done", k), {31'd0, done[k]}, 32'd0);
        end
        chk("reset_req", {31'd0, if_a.tag_rd_req}, 32'd0);
        chk("reset_bank_index", {29'd0, if_a.tag_rd_bank, if_a.tag_rd_index}, 32'd0);
        reset = 1'b0;

        // clean array: eight reads in bank/index order, no errors
        push_addrs(8);
        push_exp(z, z, z);
        pulse_start();
        wait_sb();

        // duplicate valid tag 0x5A in ways 1 and 3 of b1 i2
        fill_clean();
        mem[1][2] = pack(8'd1, 8'h5A, 8'd3, 8'h5A, 2'd1, 2'd2, 2'd1, 2'd2);
        push_addrs(8);
        push_exp(mk_res(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1010, 1),
                 mk_res(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1010, 1),
                 mk_res(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1010, 1));
        pulse_start();
        wait_sb();

        // invalid way 0 carries tag 0x07 at b0 i1; ignored when only check (a) is enabled
        fill_clean();
        mem[0][1] = pack(8'h07, 8'd2, 8'd3, 8'd4, 2'd0, 2'd1, 2'd1, 2'd1);
        push_addrs(8);
        push_exp(mk_res(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0001, 1), z,
                 mk_res(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0001, 1));
        pulse_start();
        wait_sb();

        // every set fails both checks: saturation on the 2-bit counter, first failure stays b0 i0
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 4; i++)
                mem[b][i] = pack(8'h07, 8'd1, 8'd9, 8'd9, 2'd0, 2'd1, 2'd1, 2'd1);
        push_addrs(8);
        push_exp(mk_res(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1101, 8),
                 mk_res(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1100, 8),
                 mk_res(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1101, 3));
        pulse_start();
        wait_sb();

        // read data withheld at b0 i3: timeout ends the scan with a done pulse
        fill_clean();
        wh_en = 1'b1; wh_bank = 1'b0; wh_idx = 2'd3;
        push_addrs(4);
        push_exp(mk_res(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 0),
                 mk_res(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 0),
                 mk_res(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 0));
        pulse_start();
        wait_sb();
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (if_a.tag_rd_req) cnt++;
        end
        chk("req_after_timeout", cnt, 0);
        chk("busy_after_timeout", {31'd0, busy[0]}, 32'd0);

        // abort while waiting on b1 i1: no done, error state preserved
        fill_clean();
        mem[0][1] = pack(8'h07, 8'd2, 8'd3, 8'd4, 2'd0, 2'd1, 2'd1, 2'd1);
        wh_en = 1'b1; wh_bank = 1'b1; wh_idx = 2'd1;
        push_addrs(6);
        pulse_start();
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            #1;
            if (if_a.tag_rd_req && if_a.tag_rd_gnt && if_a.tag_rd_bank && (if_a.tag_rd_index == 2'd1)) break;
            cnt++;
        end
        chk("abort_target_reached", {31'd0, (cnt < 100)}, 32'd1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        chk("abort_req", {31'd0, if_a.tag_rd_req}, 32'd0);
        chk("abort_keeps_inv", {31'd0, inv[0]}, 32'd1);
        chk("abort_keeps_cnt", cnt_of(0), 32'd1);
        chk("abort_keeps_ways", {28'd0, fways[0]}, 32'b0001);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (done[0]) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        chk("abort_reads_pending", addr_q.size(), 0);
        wh_en = 1'b0;

        // start and abort together in IDLE: start wins and clears the sticky state
        push_addrs(1);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_beats_abort", {31'd0, busy[0]}, 32'd1);
        chk("start_clears_inv", {31'd0, inv[0]}, 32'd0);
        chk("start_clears_cnt", cnt_of(0), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_in_req_busy", {31'd0, busy[0]}, 32'd0);
        chk("abort_in_req_req", {31'd0, if_a.tag_rd_req}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("stray_valid_ignored", {31'd0, busy[0]}, 32'd0);

        // asynchronous reset while a request is outstanding
        fill_clean();
        mem[0][0] = pack(8'h07, 8'd2, 8'd3, 8'd4, 2'd0, 2'd1, 2'd1, 2'd1);
        push_addrs(1);
        pulse_start();
        #1;
        chk("req_before_reset", {31'd0, if_a.tag_rd_req}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_outputs(k, z);
            chk($sformatf("dut%0d_async_reset_busy", k), {31'd0, busy[k]}, 32'd0);
        end
        chk("async_reset_req", {31'd0, if_a.tag_rd_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("after_reset_idle", {31'd0, busy[0]}, 32'd0);
        chk("final_queues_empty", q0.size() + q1.size() + q2.size() + addr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
